// File: rtl/kalman_pkg.sv
// Shared fixed-point types and widths for the Kalman filter datapath.
package kalman_pkg;

    localparam int WIDTH      = 16;
    localparam int INT_DIGITS = 5;
    localparam int FRAC       = WIDTH - INT_DIGITS;

    typedef logic signed [WIDTH-1:0]   fixed_t;
    typedef logic signed [2*WIDTH-1:0] prod_t;
    typedef logic                      req_id_t;

endpackage

// File: rtl/fxp_mul.sv
// Converts a full-width fixed-point product back to WIDTH bits (floor shift by FRAC).
// Saturates instead of wrapping when MAC_ARBITER_SAT_EN is defined.
module fxp_mul #(
    parameter int WIDTH = kalman_pkg::WIDTH,
    parameter int FRAC  = kalman_pkg::FRAC
) (
    input  logic signed [2*WIDTH-1:0] i_prod,
    output logic        [WIDTH-1:0]   o_result
);
    import kalman_pkg::*;

`ifdef MAC_ARBITER_SAT_EN
    logic signed [2*WIDTH-1:0] w_shifted;

    assign w_shifted = i_prod >>> FRAC;

    // Overflow whenever the discarded upper bits are not a pure sign extension.
    always_comb begin
        if (w_shifted[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){w_shifted[2*WIDTH-1]}}) begin
            o_result = w_shifted[WIDTH-1:0];
        end else if (w_shifted[2*WIDTH-1]) begin
            o_result = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            o_result = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign o_result = WIDTH'(i_prod >>> FRAC);
`endif

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one fixed-point MAC between two requesters.
// Define MAC_ARBITER_SAT_EN to saturate the product and accumulator sum instead of wrapping.
module mac_arbiter #(
    parameter int WIDTH      = kalman_pkg::WIDTH,
    parameter int INT_DIGITS = kalman_pkg::INT_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][WIDTH-1:0] req_a,
    input  logic [1:0][WIDTH-1:0] req_b,
    input  logic [1:0]            req_first,
    output logic [1:0]            resp_valid,
    output logic [1:0][WIDTH-1:0] resp_data
);
    import kalman_pkg::*;

    localparam int LP_FRAC = WIDTH - INT_DIGITS;

    req_id_t                  w_grant;
    logic                     w_accept;
    logic signed [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]         w_mulOut;
    logic [WIDTH-1:0]         w_sum;
    logic [WIDTH-1:0]         w_newAcc;

    req_id_t                  r_lastGrant;
    logic                     r_opValid;
    logic signed [WIDTH-1:0]  r_opA;
    logic signed [WIDTH-1:0]  r_opB;
    req_id_t                  r_opTag;
    logic                     r_opFirst;
    logic                     r_s1Valid;
    logic signed [2*WIDTH-1:0] r_s1Prod;
    req_id_t                  r_s1Tag;
    logic                     r_s1First;
    logic [1:0][WIDTH-1:0]    r_acc;
    logic [1:0]               r_respValid;
    logic [1:0][WIDTH-1:0]    r_respData;

    // Under contention the requester that did not win last time gets the multiplier.
    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b11) begin
            w_grant = ~r_lastGrant;
        end else if (req_valid[1]) begin
            w_grant = 1'b1;
        end
    end

    assign req_ready = (clk_en && !reset) ? (w_grant ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]})
                                          : 2'b00;
    assign w_accept  = |req_ready;

    assign w_prod = (2*WIDTH)'(r_opA) * (2*WIDTH)'(r_opB);

    fxp_mul #(
        .WIDTH (WIDTH),
        .FRAC  (LP_FRAC)
    ) u_fxpMul (
        .i_prod   (r_s1Prod),
        .o_result (w_mulOut)
    );

`ifdef MAC_ARBITER_SAT_EN
    logic [WIDTH:0] w_wideSum;

    assign w_wideSum = {r_acc[r_s1Tag][WIDTH-1], r_acc[r_s1Tag]} + {w_mulOut[WIDTH-1], w_mulOut};

    always_comb begin
        if (w_wideSum[WIDTH] == w_wideSum[WIDTH-1]) begin
            w_sum = w_wideSum[WIDTH-1:0];
        end else if (w_wideSum[WIDTH]) begin
            w_sum = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            w_sum = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_sum = r_acc[r_s1Tag] + w_mulOut;
`endif

    assign w_newAcc = r_s1First ? w_mulOut : w_sum;

    // Accepted operands are captured, multiplied in stage 1, then shifted and accumulated in stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lastGrant <= 1'b1;
            r_opValid   <= 1'b0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_opTag     <= 1'b0;
            r_opFirst   <= 1'b0;
            r_s1Valid   <= 1'b0;
            r_s1Prod    <= '0;
            r_s1Tag     <= 1'b0;
            r_s1First   <= 1'b0;
            r_acc       <= '0;
            r_respValid <= '0;
            r_respData  <= '0;
        end else if (clk_en) begin
            r_opValid <= w_accept;
            if (w_accept) begin
                r_opA       <= req_a[w_grant];
                r_opB       <= req_b[w_grant];
                r_opTag     <= w_grant;
                r_opFirst   <= req_first[w_grant];
                r_lastGrant <= w_grant;
            end
            r_s1Valid   <= r_opValid;
            r_s1Prod    <= w_prod;
            r_s1Tag     <= r_opTag;
            r_s1First   <= r_opFirst;
            r_respValid <= 2'b00;
            if (r_s1Valid) begin
                r_acc[r_s1Tag]       <= w_newAcc;
                r_respData[r_s1Tag]  <= w_newAcc;
                r_respValid[r_s1Tag] <= 1'b1;
            end
        end
    end

    assign resp_valid = r_respValid;
    assign resp_data  = r_respData;

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed self-checking bench for mac_arbiter; expected overflow result follows MAC_ARBITER_SAT_EN.
module tb_mac_arbiter;

    localparam int W = 16;

`ifdef MAC_ARBITER_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'h7FFF;
`else
    localparam logic [31:0] OVF_EXP = 32'hFFE0;
`endif

    logic              clk;
    logic              reset;
    logic              clk_en;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][W-1:0] req_a;
    logic [1:0][W-1:0] req_b;
    logic [1:0]        req_first;
    logic [1:0]        resp_valid;
    logic [1:0][W-1:0] resp_data;

    int compared   = 0;
    int mismatched = 0;

    mac_arbiter #(
        .WIDTH      (16),
        .INT_DIGITS (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_first  (req_first),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [W-1:0] a0, input logic [W-1:0] b0, input logic f0,
                                 input logic [W-1:0] a1, input logic [W-1:0] b1, input logic f1);
        req_valid    = valid;
        req_a[0]     = a0;
        req_b[0]     = b0;
        req_first[0] = f0;
        req_a[1]     = a1;
        req_b[1]     = b1;
        req_first[1] = f1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset  = 1'b1;
        clk_en = 1'b1;
        // Multiply request presented during reset must not be accepted.
        applyStimulus(2'b01, 16'h1000, 16'h0C00, 1'b1, 16'h0000, 16'h0000, 1'b0);
        checkOutput("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        tick();
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("reset_resp_data", 32'(resp_data), 32'h0);

        reset = 1'b0;
        #1;
        checkOutput("mul_ready", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(2'b01, 16'h0800, 16'h0800, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("acc_ready", 32'(req_ready), 32'h1);
        tick();
        checkOutput("mul_not_early", 32'(resp_valid), 32'h0);
        applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        checkOutput("mul_valid", 32'(resp_valid), 32'h1);
        checkOutput("mul_data", 32'(resp_data[0]), 32'h1800);
        tick();
        checkOutput("acc_valid", 32'(resp_valid), 32'h1);
        checkOutput("acc_data", 32'(resp_data[0]), 32'h2000);
        tick();
        checkOutput("acc_one_cycle", 32'(resp_valid), 32'h0);

        // Contention: both requesters held valid, accumulating from zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(2'b11, 16'h0800, 16'h0800, 1'b0, 16'h1000, 16'h1000, 1'b0);
        checkOutput("rr_grant0", 32'(req_ready), 32'h1);
        tick();
        checkOutput("rr_grant1", 32'(req_ready), 32'h2);
        tick();
        checkOutput("rr_grant2", 32'(req_ready), 32'h1);
        tick();
        checkOutput("rr_resp0_valid", 32'(resp_valid), 32'h1);
        checkOutput("rr_resp0_data", 32'(resp_data[0]), 32'h0800);
        checkOutput("rr_grant3", 32'(req_ready), 32'h2);
        tick();
        checkOutput("rr_resp1_valid", 32'(resp_valid), 32'h2);
        checkOutput("rr_resp1_data", 32'(resp_data[1]), 32'h2000);
        applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        checkOutput("rr_resp2_valid", 32'(resp_valid), 32'h1);
        checkOutput("rr_resp2_data", 32'(resp_data[0]), 32'h1000);
        tick();
        checkOutput("rr_resp3_valid", 32'(resp_valid), 32'h2);
        checkOutput("rr_resp3_data", 32'(resp_data[1]), 32'h4000);

        applyStimulus(2'b01, 16'hF800, 16'h0C00, 1'b1, 16'h0000, 16'h0000, 1'b0);
        tick();
        applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        checkOutput("neg_valid", 32'(resp_valid), 32'h1);
        checkOutput("neg_data", 32'(resp_data[0]), 32'hF400);

        applyStimulus(2'b01, 16'h7FFF, 16'h7FFF, 1'b1, 16'h0000, 16'h0000, 1'b0);
        tick();
        applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        checkOutput("ovf_valid", 32'(resp_valid), 32'h1);
        checkOutput("ovf_data", 32'(resp_data[0]), OVF_EXP);

        // Reset right after an accept discards the operation and clears the accumulators.
        applyStimulus(2'b01, 16'h1000, 16'h1000, 1'b1, 16'h0000, 16'h0000, 1'b0);
        tick();
        applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_data_clear", 32'(resp_data), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst_no_resp%0d", i), 32'(resp_valid), 32'h0);
        end
        applyStimulus(2'b01, 16'h0800, 16'h0800, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        checkOutput("rst_acc_valid", 32'(resp_valid), 32'h1);
        checkOutput("rst_acc_data", 32'(resp_data[0]), 32'h0800);

        // Stall: three clk_en-low cycles right after an accept delay the response by three.
        applyStimulus(2'b10, 16'h0000, 16'h0000, 1'b0, 16'h0800, 16'h0C00, 1'b1);
        checkOutput("stall_ready", 32'(req_ready), 32'h2);
        tick();
        clk_en = 1'b0;
        applyStimulus(2'b01, 16'h0800, 16'h0800, 1'b1, 16'h0000, 16'h0000, 1'b0);
        checkOutput("ready_stalled", 32'(req_ready), 32'h0);
        applyStimulus(2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("stall_frozen", 32'(resp_valid), 32'h0);
        clk_en = 1'b1;
        tick();
        checkOutput("stall_not_early", 32'(resp_valid), 32'h0);
        tick();
        checkOutput("stall_valid", 32'(resp_valid), 32'h2);
        checkOutput("stall_data", 32'(resp_data[1]), 32'h0C00);
        tick();
        checkOutput("stall_one_cycle", 32'(resp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
- REQ-001 Parameter WIDTH, default 16: fixed-point word width.
- REQ-002 Parameter INT_DIGITS, default 5: integer bits including sign. Fractional bits FRAC = WIDTH-INT_DIGITS (11 by default).
- REQ-003 Port clk, input, 1: single clock. All logic SHALL be synchronous to the rising edge.
- REQ-004 Port reset, input, 1: synchronous, active-high reset.
- REQ-005 Port clk_en, input, 1: clock enable. All state SHALL advance only when clk_en=1.
- REQ-006 Port req_valid, input, 2: per-requester operation request. Bit 0 = state-equation engine; bit 1 = covariance engine.
- REQ-007 Port req_ready, output, 2: per-requester accept strobe.
- REQ-008 Port req_a, input, 2xWIDTH: signed multiplicand, one per requester.
- REQ-009 Port req_b, input, 2xWIDTH: signed multiplier, one per requester.
- REQ-010 Port req_first, input, 2: 1 = load that requester's accumulator with the product; 0 = add the product to it.
- REQ-011 Port resp_valid, output, 2: one-cycle result strobe per requester.
- REQ-012 Port resp_data, output, 2xWIDTH: new accumulator value per requester.

Function
- REQ-013 One shared multiplier SHALL serve both requesters, with at most one accept per clk_en cycle.
- REQ-014 Handshake: an operation is accepted when req_valid[i] and req_ready[i] are both 1 at a clk_en edge. The requester SHALL hold valid and operands stable until accepted.
- REQ-015 req_ready[i] is combinational and equals clk_en AND req_valid[i] AND grant==i. req_ready SHALL be 0 while clk_en=0.
- REQ-016 Arbitration is round-robin on a last-grant pointer.
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last is granted.
  - After reset the pointer favours requester 0.
- REQ-017 Pipeline has two stages.
  - Stage 1 registers the 2*WIDTH signed product plus the requester tag and first flag.
  - Stage 2 arithmetic-shifts the product right by FRAC (truncation toward minus infinity), reduces it to WIDTH, updates the tagged accumulator, and registers resp_data.
- REQ-018 Latency: an operation accepted at clk_en edge N SHALL raise resp_valid[tag] for exactly the cycle following clk_en edge N+2. Throughput is one operation per clk_en cycle.
- REQ-019 While clk_en=0 the pipeline SHALL freeze. resp_valid is qualified by clk_en: a consumer samples it only on clk_en cycles, and it SHALL NOT be counted twice.
- REQ-020 Back-to-back accumulates from the same requester SHALL chain correctly with no bubble, because the accumulator is read and written in stage 2.
- REQ-021 Responses SHALL return in acceptance order.
- REQ-022 resp_valid[1-tag] SHALL be 0 whenever resp_valid[tag]=1.
- REQ-023 Without the saturation feature, the shift result and the accumulator sum SHALL wrap to the low WIDTH bits.

Reset
- REQ-024 When reset=1 at a clock edge (independent of clk_en):
  - req_ready, resp_valid and resp_data clear to 0;
  - both accumulators clear to 0;
  - pipeline valid bits clear;
  - the grant pointer returns to favour requester 0.
- REQ-025 Reset during an operation SHALL discard all in-flight operations with no response. An operation accepted in the same cycle as reset SHALL also be discarded.

Configuration
- REQ-026 Macro MAC_ARBITER_SAT_EN defined: the shifted product and the accumulator sum SHALL each clamp to 0x7FFF / 0x8000 (for WIDTH=16) on overflow.
- REQ-027 Macro MAC_ARBITER_SAT_EN undefined: wrap behaviour per REQ-023. Latency is identical in both builds.

Structure
- REQ-028 Shared package kalman_pkg SHALL hold WIDTH, INT_DIGITS, FRAC, typedef fixed_t (signed WIDTH), typedef prod_t (signed 2*WIDTH) and typedef req_id_t (1 bit).
- REQ-029 Sub-module fxp_mul SHALL implement the shift and the optional saturation of stage 2, so the covariance engine can reuse it.

Verification
- REQ-030 Multiply: req0 a=0x1000 (2.0), b=0x0C00 (1.5), first=1 -> resp_valid[0] 2 clk_en cycles after accept, resp_data=0x1800.
- REQ-031 Accumulate: next req0 a=0x0800, b=0x0800, first=0, back-to-back -> resp_data=0x2000.
- REQ-032 Contention: after reset, both valid in the same cycle, then held -> grants go 0,1,0,1. Responses alternate and each carries its correct tag.
- REQ-033 Negative: a=0xF800 (-1.0), b=0x0C00, first=1 -> resp_data=0xF400.
- REQ-034 Overflow: a=b=0x7FFF, first=1 -> resp_data=0x7FFF with MAC_ARBITER_SAT_EN defined, 0xFFE0 without it.
- REQ-035 Reset and stall:
  - Accept, then reset=1 in the next cycle -> no resp_valid; accumulators read 0 on the next first=0 operation.
  - clk_en low for 3 cycles mid-pipeline -> response delayed by exactly 3 cycles.
